// File: rtl/cpu_run_ctrl.sv
// Board-level run controller: debounces push-buttons and turns them, together with the
// run-mode switches and halt request, into a CPU clock-enable, a CPU reset and a cycle count.
module cpu_run_ctrl #(
    parameter int unsigned NKEY            = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned RST_PULSE       = 4,
    parameter int unsigned BURST_LEN       = 8,
    parameter int unsigned CNT_W           = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [NKEY-1:0]  KEY,
    input  logic [1:0]       MODE,
    input  logic             HALT_REQ,
    output logic             CPU_EN,
    output logic             CPU_RST,
    output logic [CNT_W-1:0] CYCLE_CNT,
    output logic [1:0]       STATE,
    output logic [NKEY-1:0]  KEY_DB
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned RP_W = $clog2(RST_PULSE + 1);
    localparam int unsigned BL_W = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {
        ST_RESET = 2'b00,
        ST_IDLE  = 2'b01,
        ST_BURST = 2'b10,
        ST_RUN   = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        M_HALT  = 2'b00,
        M_STEP  = 2'b01,
        M_BURST = 2'b10,
        M_RUN   = 2'b11
    } mode_t;

    logic [NKEY-1:0] sync1;
    logic [NKEY-1:0] sync2;
    logic [DB_W-1:0] db_cnt [NKEY];
    logic [1:0]      db_prev;
    logic [1:0]      press;

    state_t          state;
    mode_t           run_mode;
    logic [RP_W-1:0] rst_cnt;
    logic [BL_W-1:0] burst_cnt;

    assign run_mode = mode_t'(MODE);
    assign STATE    = state;

    // Keys idle high, so the synchroniser and debounced outputs reset to all ones.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1   <= '1;
            sync2   <= '1;
            KEY_DB  <= '1;
            db_prev <= '1;
            press   <= '0;
            for (int unsigned i = 0; i < NKEY; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1   <= KEY;
            sync2   <= sync1;
            db_prev <= KEY_DB[1:0];
            press   <= db_prev & ~KEY_DB[1:0];
            for (int unsigned i = 0; i < NKEY; i++) begin
                if (sync2[i] == KEY_DB[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    KEY_DB[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_RESET;
            CPU_EN    <= 1'b0;
            CPU_RST   <= 1'b1;
            CYCLE_CNT <= '0;
            rst_cnt   <= '0;
            burst_cnt <= '0;
        end else begin
            if (CPU_EN) begin
                CYCLE_CNT <= CYCLE_CNT + CNT_W'(1);
            end

            // Soft reset outranks everything else, including a same-cycle go/step press.
            if (press[1]) begin
                state     <= ST_RESET;
                CPU_EN    <= 1'b0;
                CPU_RST   <= 1'b1;
                CYCLE_CNT <= '0;
                rst_cnt   <= '0;
            end else begin
                unique case (state)
                    ST_RESET: begin
                        CPU_EN    <= 1'b0;
                        CYCLE_CNT <= '0;
                        if (rst_cnt == RP_W'(RST_PULSE - 1)) begin
                            state   <= ST_IDLE;
                            CPU_RST <= 1'b0;
                        end else begin
                            CPU_RST <= 1'b1;
                            rst_cnt <= rst_cnt + RP_W'(1);
                        end
                    end

                    ST_IDLE: begin
                        CPU_EN <= 1'b0;
                        if (press[0] && !HALT_REQ) begin
                            case (run_mode)
                                M_STEP: begin
                                    CPU_EN <= 1'b1;
                                end
                                M_BURST: begin
                                    state     <= ST_BURST;
                                    CPU_EN    <= 1'b1;
                                    burst_cnt <= BL_W'(1);
                                end
                                M_RUN: begin
                                    state  <= ST_RUN;
                                    CPU_EN <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end

                    // burst_cnt counts enabled cycles already issued, including the entry edge.
                    ST_BURST: begin
                        if (HALT_REQ || run_mode == M_HALT || burst_cnt == BL_W'(BURST_LEN)) begin
                            state  <= ST_IDLE;
                            CPU_EN <= 1'b0;
                        end else begin
                            CPU_EN    <= 1'b1;
                            burst_cnt <= burst_cnt + BL_W'(1);
                        end
                    end

                    ST_RUN: begin
                        if (HALT_REQ || run_mode != M_RUN || press[0]) begin
                            state  <= ST_IDLE;
                            CPU_EN <= 1'b0;
                        end else begin
                            CPU_EN <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed and randomized step/burst/run/reset scenarios, each
// predicted as a number of enabled cycles and a running cycle count.
module tb_cpu_run_ctrl;

    localparam int unsigned D  = 4;
    localparam int unsigned RP = 3;
    localparam int unsigned BL = 5;
    // Raw key fall to the edge where the FSM reacts: synchroniser + debounce + press register.
    localparam int unsigned PRESS_LAT = 2 + D + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  key;
    logic [1:0]  mode;
    logic        halt;

    logic        en,  cpu_rst;
    logic [31:0] cnt;
    logic [1:0]  state, key_db;
    logic        en4, cpu_rst4;
    logic [3:0]  cnt4;
    logic [1:0]  state4, key_db4;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;
    int unsigned en_count = 0;
    int unsigned pulse_count = 0;
    bit          en_prev = 1'b0;
    logic [31:0] model_cnt = '0;

    cpu_run_ctrl #(.NKEY(2), .DEBOUNCE_CYCLES(D), .RST_PULSE(RP), .BURST_LEN(BL), .CNT_W(32)) dut (
        .CLK(clk), .RST(rst), .KEY(key), .MODE(mode), .HALT_REQ(halt),
        .CPU_EN(en), .CPU_RST(cpu_rst), .CYCLE_CNT(cnt), .STATE(state), .KEY_DB(key_db)
    );

    cpu_run_ctrl #(.NKEY(2), .DEBOUNCE_CYCLES(D), .RST_PULSE(RP), .BURST_LEN(BL), .CNT_W(4)) dut4 (
        .CLK(clk), .RST(rst), .KEY(key), .MODE(mode), .HALT_REQ(halt),
        .CPU_EN(en4), .CPU_RST(cpu_rst4), .CYCLE_CNT(cnt4), .STATE(state4), .KEY_DB(key_db4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (en === 1'b1) begin
            en_count++;
            if (!en_prev) pulse_count++;
        end
        en_prev = (en === 1'b1);
    endtask

    task automatic ticks(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_state"},  64'(state),    64'd0);
        check({tag, "_en"},     64'(en),       64'd0);
        check({tag, "_cpurst"}, 64'(cpu_rst),  64'd1);
        check({tag, "_cnt"},    64'(cnt),      64'd0);
        check({tag, "_kdb"},    64'(key_db),   64'd3);
        check({tag, "_state4"}, 64'(state4),   64'd0);
        check({tag, "_cpurst4"},64'(cpu_rst4), 64'd1);
        check({tag, "_cnt4"},   64'(cnt4),     64'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_state"},  64'(state),    64'd1);
        check({tag, "_en"},     64'(en),       64'd0);
        check({tag, "_cpurst"}, 64'(cpu_rst),  64'd0);
        check({tag, "_cnt"},    64'(cnt),      64'(model_cnt));
        check({tag, "_kdb"},    64'(key_db),   64'd3);
        check({tag, "_cnt4"},   64'(cnt4),     64'(model_cnt[3:0]));
        check({tag, "_en4"},    64'(en4),      64'd0);
        check({tag, "_state4"}, 64'(state4),   64'd1);
        check({tag, "_kdb4"},   64'(key_db4),  64'd3);
    endtask

    task automatic do_async_reset(input string tag);
        int unsigned t;
        rst = 1'b1;
        #1;
        check_reset({tag, "_imm"});
        ticks(2);
        check_reset({tag, "_hold"});
        rst = 1'b0;
        t = 0;
        do begin tick(); t++; end while (cpu_rst === 1'b1 && t < 30);
        check({tag, "_pulse"}, 64'(t), 64'(RP));
        model_cnt = '0;
        check_idle(tag);
    endtask

    task automatic press_key(input int unsigned k, input int unsigned hold);
        key[k] = 1'b0;
        ticks(hold);
        key[k] = 1'b1;
    endtask

    task automatic do_step();
        int unsigned b, p;
        b = en_count; p = pulse_count;
        mode = 2'b01;
        press_key(0, 8);
        ticks(8);
        check("step_en", 64'(en_count - b), 64'd1);
        check("step_pulses", 64'(pulse_count - p), 64'd1);
        model_cnt += 1;
        check_idle("step");
    endtask

    task automatic do_glitch(input int unsigned g);
        int unsigned b;
        b = en_count;
        mode = 2'b01;
        key[0] = 1'b0;
        for (int unsigned t = 0; t < g + 8; t++) begin
            tick();
            if (t + 1 == g) key[0] = 1'b1;
            check("glitch_kdb", 64'(key_db), 64'd3);
        end
        ticks(4);
        check("glitch_en", 64'(en_count - b), 64'd0);
        check_idle("glitch");
    endtask

    // kind: 0 none, 1 HALT_REQ abort, 2 MODE=HALT abort, 3 other mode change (ignored)
    task automatic do_burst(input int unsigned kind, input int unsigned at);
        int unsigned b, p, expd;
        bit fired;
        b = en_count; p = pulse_count; fired = 1'b0;
        mode = 2'b10;
        key[0] = 1'b0;
        for (int unsigned t = 1; t <= 30; t++) begin
            tick();
            if (t == 8) key[0] = 1'b1;
            halt = 1'b0;
            if (kind != 0 && !fired && en === 1'b1 && en_count - b == at) begin
                fired = 1'b1;
                case (kind)
                    1: halt = 1'b1;
                    2: mode = 2'b00;
                    default: mode = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11;
                endcase
            end
        end
        halt = 1'b0;
        expd = (kind == 1 || kind == 2) ? at : BL;
        check("burst_en", 64'(en_count - b), 64'(expd));
        check("burst_pulses", 64'(pulse_count - p), 64'd1);
        model_cnt += expd;
        check_idle("burst");
    endtask

    task automatic start_run(input int unsigned n);
        int unsigned b, t;
        b = en_count; t = 0;
        mode = 2'b11;
        key[0] = 1'b0;
        while (en_count - b < n && t < 200) begin
            tick(); t++;
            if (t == 8) key[0] = 1'b1;
        end
        key[0] = 1'b1;
        check("run_reach", 64'(en_count - b), 64'(n));
    endtask

    // stop: 0 HALT_REQ, 1 mode change away from RUN, 2 second press (toggle)
    task automatic do_run(input int unsigned n, input int unsigned stop);
        int unsigned b, expd;
        b = en_count;
        start_run(n);
        case (stop)
            0: begin halt = 1'b1; tick(); halt = 1'b0; end
            1: mode = 2'($urandom_range(0, 2));
            default: press_key(0, 8);
        endcase
        ticks(12);
        expd = n + ((stop == 2) ? PRESS_LAT - 1 : 0);
        check("run_en", 64'(en_count - b), 64'(expd));
        model_cnt += expd;
        check_idle("run");
    endtask

    task automatic do_soft(input bit both, input int unsigned n);
        int unsigned b, t;
        if (both) begin
            mode = 2'b11;
            b = en_count;
            key = 2'b00;
        end else begin
            start_run(n);
            b = en_count;
            key[1] = 1'b0;
        end
        t = 0;
        do begin tick(); t++; end while (cpu_rst !== 1'b1 && t < 30);
        check("srst_lat", 64'(t), 64'(PRESS_LAT));
        check("srst_state", 64'(state), 64'd0);
        check("srst_en", 64'(en), 64'd0);
        check("srst_cnt", 64'(cnt), 64'd0);
        check("srst_cnt4", 64'(cnt4), 64'd0);
        key = 2'b11;
        t = 0;
        do begin tick(); t++; end while (cpu_rst === 1'b1 && t < 30);
        check("srst_pulse", 64'(t), 64'(RP));
        model_cnt = '0;
        ticks(10);
        if (both) check("srst_both_en", 64'(en_count - b), 64'd0);
        check_idle("srst");
    endtask

    // kind 0: MODE=HALT; kind 1: HALT_REQ held with an active mode
    task automatic do_ignored(input int unsigned kind);
        int unsigned b;
        b = en_count;
        if (kind == 0) mode = 2'b00;
        else begin
            mode = 2'($urandom_range(1, 3));
            halt = 1'b1;
        end
        press_key(0, 8);
        ticks(8);
        halt = 1'b0;
        check("ignored_en", 64'(en_count - b), 64'd0);
        check_idle("ignored");
    endtask

    initial begin
        int unsigned b, p;
        key = 2'b11; mode = 2'b00; halt = 1'b0;
        do_async_reset("por");

        do_glitch(D - 1);

        mode = 2'b01;
        b = en_count; p = pulse_count;
        key[0] = 1'b0;
        for (int unsigned t = 1; t <= 10; t++) begin
            tick();
            check("db_edge", 64'(key_db[0]), (t >= 2 + D) ? 64'd0 : 64'd1);
        end
        key[0] = 1'b1;
        ticks(10);
        check("db_press_en", 64'(en_count - b), 64'd1);
        check("db_press_pulses", 64'(pulse_count - p), 64'd1);
        model_cnt += 1;
        check_idle("db");

        do_step();
        do_step();
        check("three_steps", 64'(cnt), 64'd3);

        do_burst(0, 0);
        do_burst(1, 3);

        do_run(20, 0);
        do_soft(1'b0, 10);
        check("after_srst_cnt", 64'(cnt), 64'd0);
        do_soft(1'b1, 0);

        do_ignored(0);
        do_ignored(1);

        do_async_reset("wrap_rst");
        do_run(17, 0);
        check("wrap_cnt4", 64'(cnt4), 64'd1);
        do_run(9, 1);

        start_run(10);
        do_async_reset("midrun");

        for (int unsigned it = 0; it < 24; it++) begin
            case ($urandom_range(0, 5))
                0: do_step();
                1: do_burst($urandom_range(0, 3), $urandom_range(1, BL));
                2: do_run($urandom_range(8, 30), $urandom_range(0, 2));
                3: do_soft(1'b0, $urandom_range(8, 20));
                4: do_ignored($urandom_range(0, 1));
                default: do_glitch($urandom_range(1, D - 1));
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
